// File: rtl/vec_elem_serializer.sv
`default_nettype none
// ============================================================================
// Module   : vec_elem_serializer
// Purpose  : Takes one NUM_ELEM*ELEM_WIDTH vector per enqueue and emits its
//            elements one per dequeue, lowest element first. A current
//            register plus a prefetch register let the next vector land
//            while the current one drains, so output has no gap between
//            vectors.
// Ports    : CLK, nRST        clock, synchronous active-low reset
//            in_enq__ENA      enqueue in_enq_v this cycle
//            in_enq_v         input vector, element k at [k*ELEM_WIDTH +: ELEM_WIDTH]
//            in_enq__RDY      prefetch register empty
//            out_deq__ENA     consume current element
//            out_deq__RDY     current register holds a vector
//            out_first        current element
//            out_first__RDY   same as out_deq__RDY
//            out_last         current element is the vector's last
// Revision : 1.0  initial release
// ============================================================================
module vec_elem_serializer #(
   parameter int ELEM_WIDTH = 32,
   parameter int NUM_ELEM   = 3
) (
   input  logic                           CLK,
   input  logic                           nRST,
   input  logic                           in_enq__ENA,
   input  logic [NUM_ELEM*ELEM_WIDTH-1:0] in_enq_v,
   output logic                           in_enq__RDY,
   input  logic                           out_deq__ENA,
   output logic                           out_deq__RDY,
   output logic [ELEM_WIDTH-1:0]          out_first,
   output logic                           out_first__RDY,
   output logic                           out_last
);

   localparam int                c_IDX_W    = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
   localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_ELEM - 1);

   logic [NUM_ELEM*ELEM_WIDTH-1:0] r_cur_data;
   logic [NUM_ELEM*ELEM_WIDTH-1:0] r_nxt_data;
   logic                           r_cur_valid;
   logic                           r_nxt_valid;
   logic [c_IDX_W-1:0]             r_idx;

   logic                           w_enq;
   logic                           w_deq;
   logic                           w_last;
   logic [ELEM_WIDTH-1:0]          w_elem [NUM_ELEM];

   // Firing conditions: an ENA without its RDY is ignored.
   assign w_enq  = in_enq__ENA  & ~r_nxt_valid;
   assign w_deq  = out_deq__ENA &  r_cur_valid;
   assign w_last = w_deq & (r_idx == c_LAST_IDX);

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         r_cur_data  <= '0;
         r_nxt_data  <= '0;
         r_cur_valid <= 1'b0;
         r_nxt_valid <= 1'b0;
         r_idx       <= '0;
      end else if (!r_cur_valid) begin
         // EMPTY: a new vector goes straight into the current register.
         if (w_enq) begin
            r_cur_data  <= in_enq_v;
            r_cur_valid <= 1'b1;
            r_idx       <= '0;
         end
      end else if (!r_nxt_valid) begin
         // ONE: an enqueue on the last dequeue refills current directly,
         // otherwise it parks in the prefetch register.
         if (w_last) begin
            r_idx <= '0;
            if (w_enq) begin
               r_cur_data <= in_enq_v;
            end else begin
               r_cur_valid <= 1'b0;
            end
         end else begin
            if (w_deq) begin
               r_idx <= r_idx + c_IDX_W'(1);
            end
            if (w_enq) begin
               r_nxt_data  <= in_enq_v;
               r_nxt_valid <= 1'b1;
            end
         end
      end else begin
         // TWO: the prefetched vector is promoted when current finishes.
         if (w_last) begin
            r_cur_data  <= r_nxt_data;
            r_nxt_valid <= 1'b0;
            r_idx       <= '0;
         end else if (w_deq) begin
            r_idx <= r_idx + c_IDX_W'(1);
         end
      end
   end

   for (genvar k = 0; k < NUM_ELEM; k++) begin : g_elem
      assign w_elem[k] = r_cur_data[k*ELEM_WIDTH +: ELEM_WIDTH];
   end

   assign in_enq__RDY    = ~r_nxt_valid;
   assign out_deq__RDY   = r_cur_valid;
   assign out_first__RDY = r_cur_valid;
   assign out_first      = w_elem[r_idx];
   assign out_last       = r_cur_valid & (r_idx == c_LAST_IDX);

endmodule
`default_nettype wire

// File: tb/tb_vec_elem_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vec_elem_serializer
// Purpose  : Scoreboard bench for vec_elem_serializer. The stimulus side
//            pushes every accepted vector's elements into an expected queue;
//            a monitor on the falling edge compares output element, last
//            flag and both RDY signals against the queue contents.
// Revision : 1.0  initial release
// ============================================================================
module tb_vec_elem_serializer;

   localparam int W = 32;
   localparam int N = 3;

   typedef struct {
      logic [W-1:0] d;
      bit           l;
   } exp_t;

   logic             CLK = 1'b0;
   logic             nRST;
   logic             in_enq__ENA;
   logic [N*W-1:0]   in_enq_v;
   logic             in_enq__RDY;
   logic             out_deq__ENA;
   logic             out_deq__RDY;
   logic [W-1:0]     out_first;
   logic             out_first__RDY;
   logic             out_last;

   exp_t q[$];
   bit   pend   = 1'b0;   // a vector was pushed this cycle but has not been accepted yet
   bit   mon_en = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   vec_elem_serializer #(.ELEM_WIDTH(W), .NUM_ELEM(N)) dut (
      .CLK            (CLK),
      .nRST           (nRST),
      .in_enq__ENA    (in_enq__ENA),
      .in_enq_v       (in_enq_v),
      .in_enq__RDY    (in_enq__RDY),
      .out_deq__ENA   (out_deq__ENA),
      .out_deq__RDY   (out_deq__RDY),
      .out_first      (out_first),
      .out_first__RDY (out_first__RDY),
      .out_last       (out_last)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Vectors held = number of elements still owed, rounded up to whole vectors.
   function automatic int vecs_held(input int elems);
      return (elems + N - 1) / N;
   endfunction

   // Monitor: sampled mid-cycle, away from the active edge.
   always @(negedge CLK) begin
      if (mon_en) begin
         int held;
         held = q.size() - (pend ? N : 0);
         chk("enq_rdy",   W'(in_enq__RDY),    W'(vecs_held(held) < 2));
         chk("deq_rdy",   W'(out_deq__RDY),   W'(held > 0));
         chk("first_rdy", W'(out_first__RDY), W'(held > 0));
         if (held > 0) begin
            chk("first", out_first, q[0].d);
            chk("last",  W'(out_last), W'(q[0].l));
            if (out_deq__ENA && nRST) void'(q.pop_front());
         end
      end
   end

   // One stimulus cycle, called just after a rising edge.
   task automatic cyc(input bit e, input logic [N*W-1:0] v, input bit d);
      bit rdy;
      rdy          = vecs_held(q.size()) < 2;
      in_enq__ENA  = e;
      in_enq_v     = v;
      out_deq__ENA = d;
      pend         = e && rdy;
      if (pend) begin
         for (int k = 0; k < N; k++) begin
            exp_t x;
            x.d = v[k*W +: W];
            x.l = (k == N - 1);
            q.push_back(x);
         end
      end
      @(posedge CLK); #1;
      pend = 1'b0;
   endtask

   task automatic do_reset();
      nRST = 1'b0; in_enq__ENA = 1'b0; out_deq__ENA = 1'b0; pend = 1'b0;
      in_enq_v = {$urandom, $urandom, $urandom};
      @(posedge CLK); #1;
      q.delete();
      nRST   = 1'b1;
      mon_en = 1'b1;
      @(negedge CLK);
      chk("rst_enq_rdy", W'(in_enq__RDY),  W'(1));
      chk("rst_deq_rdy", W'(out_deq__RDY), W'(0));
      chk("rst_first",   out_first,        W'(0));
      chk("rst_last",    W'(out_last),     W'(0));
      @(posedge CLK); #1;
   endtask

   function automatic logic [N*W-1:0] rvec();
      return {$urandom, $urandom, $urandom};
   endfunction

   initial begin
      nRST = 1'b0; in_enq__ENA = 1'b0; out_deq__ENA = 1'b0; in_enq_v = '0;
      @(posedge CLK); #1;
      do_reset();

      // Idle a few cycles, including deq while empty (must be ignored).
      cyc(0, '0, 0);
      cyc(0, '0, 1);

      // Single vector A,B,C drained with deq every cycle.
      cyc(1, {32'hC, 32'hB, 32'hA}, 0);
      repeat (4) cyc(0, '0, 1);

      // Back-to-back vectors with deq always high.
      cyc(1, rvec(), 1);
      cyc(1, rvec(), 1);
      repeat (7) cyc(0, '0, 1);

      // Enqueue coinciding with the last dequeue while in ONE.
      cyc(1, rvec(), 0);
      cyc(0, '0, 1);
      cyc(0, '0, 1);
      cyc(1, rvec(), 1);
      repeat (4) cyc(0, '0, 1);

      // Stall five cycles in TWO; an enq attempt while full is ignored.
      cyc(1, rvec(), 0);
      cyc(1, rvec(), 1);
      repeat (5) cyc($urandom_range(0, 1), rvec(), 0);
      repeat (7) cyc(0, '0, 1);

      // Reset after one element consumed with prefetch full.
      cyc(1, rvec(), 0);
      cyc(1, rvec(), 1);
      do_reset();
      cyc(1, {32'h3, 32'h2, 32'h1}, 0);
      repeat (4) cyc(0, '0, 1);

      // Randomised traffic, including ENA while RDY is low.
      for (int i = 0; i < 2000; i++) begin
         cyc($urandom_range(0, 9) < 6, rvec(), $urandom_range(0, 9) < 7);
         if (i == 1200) do_reset();
      end
      repeat (8) cyc(0, '0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
